// File: rtl/regfile_cmd_ctrl.sv
// Byte-stream command decoder that turns write/read frames into regFile strobes
// and returns read data on a valid/ready TX byte interface.
module regfile_cmd_ctrl #(
   parameter int                    DATA_WIDTH = 8,
   parameter int                    ADDR_WIDTH = 4,
   parameter logic [DATA_WIDTH-1:0] WR_CMD     = 8'hAA,
   parameter logic [DATA_WIDTH-1:0] RD_CMD     = 8'hBB,
   parameter int                    RD_TIMEOUT = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] rx_data,
   input  logic                  rx_valid,
   output logic [DATA_WIDTH-1:0] tx_data,
   output logic                  tx_valid,
   input  logic                  tx_ready,
   output logic [ADDR_WIDTH-1:0] rf_addr,
   output logic [DATA_WIDTH-1:0] rf_wrData,
   output logic                  rf_wrEn,
   output logic                  rf_rdEn,
   input  logic [DATA_WIDTH-1:0] rf_rdData,
   input  logic                  rf_rdData_valid,
   output logic                  busy,
   output logic                  err
);

   localparam int CNT_W = $clog2(RD_TIMEOUT + 1);

   typedef enum logic [2:0] {
      IDLE,
      WR_ADDR,
      WR_DATA,
      WR_EXEC,
      RD_ADDR,
      RD_EXEC,
      RD_WAIT,
      TX
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] wait_cnt;
   logic             addr_ok;
   logic             addr_phase;

   // An address byte is only legal if the bits above the regFile depth are clear.
   assign addr_ok    = (rx_data[DATA_WIDTH-1:ADDR_WIDTH] == '0);
   assign addr_phase = (state == WR_ADDR) || (state == RD_ADDR);

   always_comb begin
      state_nxt = state;
      err       = 1'b0;
      rf_wrEn   = 1'b0;
      rf_rdEn   = 1'b0;
      tx_valid  = 1'b0;
      busy      = (state != IDLE);
      case (state)
         IDLE: begin
            if (rx_valid) begin
               if (rx_data == WR_CMD) begin
                  state_nxt = WR_ADDR;
               end else if (rx_data == RD_CMD) begin
                  state_nxt = RD_ADDR;
               end
            end
         end
         WR_ADDR: begin
            if (rx_valid) begin
               if (addr_ok) begin
                  state_nxt = WR_DATA;
               end else begin
                  err       = 1'b1;
                  state_nxt = IDLE;
               end
            end
         end
         WR_DATA: begin
            if (rx_valid) begin
               state_nxt = WR_EXEC;
            end
         end
         WR_EXEC: begin
            rf_wrEn   = 1'b1;
            state_nxt = IDLE;
         end
         RD_ADDR: begin
            if (rx_valid) begin
               if (addr_ok) begin
                  state_nxt = RD_EXEC;
               end else begin
                  err       = 1'b1;
                  state_nxt = IDLE;
               end
            end
         end
         RD_EXEC: begin
            rf_rdEn   = 1'b1;
            state_nxt = RD_WAIT;
         end
         RD_WAIT: begin
            // Data arriving on the last permitted cycle still wins over the timeout.
            if (rf_rdData_valid) begin
               state_nxt = TX;
            end else if (wait_cnt == CNT_W'(RD_TIMEOUT - 1)) begin
               err       = 1'b1;
               state_nxt = IDLE;
            end
         end
         TX: begin
            tx_valid = 1'b1;
            if (tx_ready) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         rf_addr   <= '0;
         rf_wrData <= '0;
         tx_data   <= '0;
         wait_cnt  <= '0;
      end else begin
         state <= state_nxt;
         // A rejected address leaves the previous rf_addr untouched.
         if (addr_phase && rx_valid && addr_ok) begin
            rf_addr <= rx_data[ADDR_WIDTH-1:0];
         end
         if ((state == WR_DATA) && rx_valid) begin
            rf_wrData <= rx_data;
         end
         if (state == RD_EXEC) begin
            wait_cnt <= '0;
         end else if (state == RD_WAIT) begin
            wait_cnt <= wait_cnt + 1'b1;
         end
         if ((state == RD_WAIT) && rf_rdData_valid) begin
            tx_data <= rf_rdData;
         end
      end
   end

endmodule

// File: tb/tb_regfile_cmd_ctrl.sv
// Scoreboard bench for regfile_cmd_ctrl: directed frames against a small regFile
// stub with programmable read latency.
module tb_regfile_cmd_ctrl;

   localparam int RD_TIMEOUT = 4;
   localparam int K_WR  = 0;
   localparam int K_RD  = 1;
   localparam int K_TX  = 2;
   localparam int K_ERR = 3;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] rx_data = 8'h00;
   logic       rx_valid = 1'b0;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready = 1'b1;
   logic [3:0] rf_addr;
   logic [7:0] rf_wrData;
   logic       rf_wrEn;
   logic       rf_rdEn;
   logic [7:0] rf_rdData = 8'h00;
   logic       rf_rdData_valid = 1'b0;
   logic       busy;
   logic       err;

   typedef struct {
      int         kind;
      logic [3:0] addr;
      logic [7:0] data;
      int         lat;
   } exp_t;

   exp_t sb[$];
   int   vec_count = 0;
   int   miscompares = 0;
   int   cycle = 0;
   int   last_rd_cycle = 0;

   logic [7:0] mem [16];
   logic [3:0] pend_addr = 4'h0;
   int         pend_cnt = 0;
   int         stub_delay = 0;
   logic       stub_mute = 1'b0;

   regfile_cmd_ctrl #(
      .DATA_WIDTH(8),
      .ADDR_WIDTH(4),
      .WR_CMD(8'hAA),
      .RD_CMD(8'hBB),
      .RD_TIMEOUT(RD_TIMEOUT)
   ) dut (
      .clk(clk),
      .rst(rst),
      .rx_data(rx_data),
      .rx_valid(rx_valid),
      .tx_data(tx_data),
      .tx_valid(tx_valid),
      .tx_ready(tx_ready),
      .rf_addr(rf_addr),
      .rf_wrData(rf_wrData),
      .rf_wrEn(rf_wrEn),
      .rf_rdEn(rf_rdEn),
      .rf_rdData(rf_rdData),
      .rf_rdData_valid(rf_rdData_valid),
      .busy(busy),
      .err(err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cycle <= cycle + 1;

   // regFile stub: read data appears stub_delay cycles after the 1-cycle nominal latency.
   always @(posedge clk) begin
      rf_rdData_valid <= 1'b0;
      if (rf_wrEn) mem[rf_addr] <= rf_wrData;
      if (rf_rdEn && !stub_mute) begin
         if (stub_delay == 0) begin
            rf_rdData       <= mem[rf_addr];
            rf_rdData_valid <= 1'b1;
         end else begin
            pend_addr <= rf_addr;
            pend_cnt  <= stub_delay;
         end
      end else if (pend_cnt != 0) begin
         pend_cnt <= pend_cnt - 1;
         if (pend_cnt == 1) begin
            rf_rdData       <= mem[pend_addr];
            rf_rdData_valid <= 1'b1;
         end
      end
   end

   function automatic string kindName(input int k);
      case (k)
         K_WR:    return "wr";
         K_RD:    return "rd";
         K_TX:    return "tx";
         default: return "err";
      endcase
   endfunction

   task automatic pushExp(input int kind, input logic [3:0] addr, input logic [7:0] data, input int lat);
      exp_t e;
      e.kind = kind;
      e.addr = addr;
      e.data = data;
      e.lat  = lat;
      sb.push_back(e);
   endtask

   task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
      vec_count++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cycle);
      end
   endtask

   task automatic checkEvent(input int kind, input logic [3:0] addr, input logic [7:0] data, input int lat);
      exp_t e;
      logic ok;
      vec_count++;
      if (sb.size() == 0) begin
         miscompares++;
         $display("[TB] FAIL unexpected_%s: got addr=0x%0h data=0x%0h, expected no event (cycle %0d)",
                  kindName(kind), addr, data, cycle);
      end else begin
         e  = sb.pop_front();
         ok = (e.kind == kind);
         if (ok && (kind == K_WR || kind == K_RD)) ok = (e.addr == addr);
         if (ok && (kind == K_WR || kind == K_TX)) ok = (e.data == data);
         if (ok && kind == K_ERR && e.lat >= 0) ok = (e.lat == lat);
         if (!ok) begin
            miscompares++;
            $display("[TB] FAIL event_%s: got %s addr=0x%0h data=0x%0h lat=%0d, expected %s addr=0x%0h data=0x%0h lat=%0d",
                     kindName(e.kind), kindName(kind), addr, data, lat,
                     kindName(e.kind), e.addr, e.data, e.lat);
         end
      end
   endtask

   // Monitor: every observable DUT event must match the head of the scoreboard.
   always @(negedge clk) begin
      if (!rst) begin
         if (rf_wrEn || rf_rdEn) begin
            vec_count++;
            if (rf_wrEn && rf_rdEn) begin
               miscompares++;
               $display("[TB] FAIL strobe_exclusive: got wrEn=1 rdEn=1, expected at most one");
            end
         end
         if (rf_wrEn) checkEvent(K_WR, rf_addr, rf_wrData, 0);
         if (rf_rdEn) begin
            last_rd_cycle = cycle;
            checkEvent(K_RD, rf_addr, 8'h00, 0);
         end
         if (tx_valid && tx_ready) checkEvent(K_TX, 4'h0, tx_data, 0);
         if (err) checkEvent(K_ERR, 4'h0, 8'h00, cycle - last_rd_cycle);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic applyStimulus(input logic [7:0] b);
      rx_data  = b;
      rx_valid = 1'b1;
      step();
      rx_valid = 1'b0;
   endtask

   task automatic waitTxValid(input int budget, output int waited);
      waited = 0;
      for (int i = 1; i <= budget; i++) begin
         @(negedge clk);
         if (tx_valid) begin
            waited = i;
            break;
         end
      end
      if (waited == 0) begin
         vec_count++;
         miscompares++;
         $display("[TB] FAIL tx_valid_wait: got no tx_valid, expected within %0d cycles", budget);
      end
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "_tx_data"}, tx_data, 8'h00);
      checkOutput({tag, "_tx_valid"}, {7'b0, tx_valid}, 8'h00);
      checkOutput({tag, "_rf_addr"}, {4'b0, rf_addr}, 8'h00);
      checkOutput({tag, "_rf_wrData"}, rf_wrData, 8'h00);
      checkOutput({tag, "_rf_wrEn"}, {7'b0, rf_wrEn}, 8'h00);
      checkOutput({tag, "_rf_rdEn"}, {7'b0, rf_rdEn}, 8'h00);
      checkOutput({tag, "_busy"}, {7'b0, busy}, 8'h00);
      checkOutput({tag, "_err"}, {7'b0, err}, 8'h00);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got no completion, expected finish before 200000 ns");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int lat_seen;
      int err_seen;

      for (int i = 0; i < 16; i++) mem[i] = 8'h00;
      mem[3] = 8'h0F;

      // Reset state
      step();
      @(negedge clk);
      checkAllZero("reset");
      step();
      rst = 1'b0;

      // Write 5 <= 0A, then read it back
      pushExp(K_WR, 4'h5, 8'h0A, 0);
      applyStimulus(8'hAA);
      applyStimulus(8'h05);
      applyStimulus(8'h0A);
      idle(2);
      pushExp(K_RD, 4'h5, 8'h00, 0);
      pushExp(K_TX, 4'h0, 8'h0A, 0);
      applyStimulus(8'hBB);
      applyStimulus(8'h05);
      idle(6);

      // Read 3 with tx_ready held low for 5 cycles
      tx_ready = 1'b0;
      pushExp(K_RD, 4'h3, 8'h00, 0);
      pushExp(K_TX, 4'h0, 8'h0F, 0);
      applyStimulus(8'hBB);
      applyStimulus(8'h03);
      waitTxValid(10, lat_seen);
      checkOutput("rd_latency", 8'(lat_seen), 8'd3);
      for (int i = 0; i < 5; i++) begin
         checkOutput("tx_hold_valid", {7'b0, tx_valid}, 8'h01);
         checkOutput("tx_hold_data", tx_data, 8'h0F);
         @(negedge clk);
      end
      step();
      tx_ready = 1'b1;
      step();
      @(negedge clk);
      checkOutput("tx_drop_valid", {7'b0, tx_valid}, 8'h00);
      checkOutput("tx_drop_busy", {7'b0, busy}, 8'h00);
      step();

      // Bad opcode, bad address, then a normal write
      applyStimulus(8'h55);
      @(negedge clk);
      checkOutput("bad_opcode_busy", {7'b0, busy}, 8'h00);
      step();
      pushExp(K_ERR, 4'h0, 8'h00, -1);
      applyStimulus(8'hAA);
      applyStimulus(8'h13);
      @(negedge clk);
      checkOutput("bad_addr_busy", {7'b0, busy}, 8'h00);
      step();
      pushExp(K_WR, 4'h2, 8'h33, 0);
      applyStimulus(8'hAA);
      applyStimulus(8'h02);
      applyStimulus(8'h33);
      idle(2);

      // Read timeout with a mute regFile
      stub_mute = 1'b1;
      pushExp(K_RD, 4'h3, 8'h00, 0);
      pushExp(K_ERR, 4'h0, 8'h00, RD_TIMEOUT);
      applyStimulus(8'hBB);
      applyStimulus(8'h03);
      err_seen = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (err) begin
            err_seen = 1;
            break;
         end
      end
      checkOutput("timeout_err_seen", 8'(err_seen), 8'h01);
      step();
      @(negedge clk);
      checkOutput("timeout_busy", {7'b0, busy}, 8'h00);
      checkOutput("timeout_tx_valid", {7'b0, tx_valid}, 8'h00);
      step();
      stub_mute = 1'b0;
      idle(2);

      // Reset while in WR_DATA; the late data byte must not cause a write
      applyStimulus(8'hAA);
      applyStimulus(8'h02);
      rst = 1'b1;
      step();
      rst = 1'b0;
      @(negedge clk);
      checkAllZero("rst_wr_data");
      step();
      applyStimulus(8'h44);
      idle(3);

      // Reset while in TX
      tx_ready = 1'b0;
      pushExp(K_RD, 4'h3, 8'h00, 0);
      applyStimulus(8'hBB);
      applyStimulus(8'h03);
      waitTxValid(10, lat_seen);
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      @(negedge clk);
      checkAllZero("rst_tx");
      step();
      tx_ready = 1'b1;
      idle(2);

      // rx bytes during RD_WAIT and TX are dropped; data on the last wait cycle is accepted
      stub_delay = 3;
      tx_ready   = 1'b0;
      pushExp(K_RD, 4'h3, 8'h00, 0);
      pushExp(K_TX, 4'h0, 8'h0F, 0);
      applyStimulus(8'hBB);
      applyStimulus(8'h03);
      step();
      applyStimulus(8'hAA);
      applyStimulus(8'hBB);
      waitTxValid(10, lat_seen);
      step();
      applyStimulus(8'hAA);
      tx_ready = 1'b1;
      step();
      @(negedge clk);
      checkOutput("drop_in_tx_busy", {7'b0, busy}, 8'h00);
      step();
      stub_delay = 0;
      idle(2);

      // Back-to-back write frames, then read the first back
      pushExp(K_WR, 4'h1, 8'h11, 0);
      pushExp(K_WR, 4'h2, 8'h22, 0);
      applyStimulus(8'hAA);
      applyStimulus(8'h01);
      applyStimulus(8'h11);
      step();
      applyStimulus(8'hAA);
      applyStimulus(8'h02);
      applyStimulus(8'h22);
      idle(2);
      pushExp(K_RD, 4'h1, 8'h00, 0);
      pushExp(K_TX, 4'h0, 8'h11, 0);
      applyStimulus(8'hBB);
      applyStimulus(8'h01);
      idle(6);

      checkOutput("scoreboard_drained", 8'(sb.size()), 8'h00);
      $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
      $finish;
   end

endmodule
